// File: rtl/mmio_pkg.sv
// Shared MMIO constants for the store/load routing paths: region nibbles,
// IO register addresses, store funct3 encodings and the lane-mask helper.
package mmio_pkg;

  localparam int unsigned XLEN = 32;

  // Region decode on addr[31:28]: DMEM is 4'b00x1, IMEM is 4'b001x, IO is 4'b1000
  localparam logic [1:0] REGION_DMEM_HI = 2'b00;
  localparam logic       REGION_DMEM_LO = 1'b1;
  localparam logic [2:0] REGION_IMEM_HI = 3'b001;
  localparam logic [3:0] REGION_IO      = 4'b1000;

  localparam logic [XLEN-1:0] UART_TX_ADDR = 32'h8000_0008;
  localparam logic [XLEN-1:0] CNT_RST_ADDR = 32'h8000_0018;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Byte-enable mask for a store of the given width at byte offset off
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (f3)
      F3_SB:   m = 4'b0001 << off;
      F3_SH:   m = 4'b0011 << {off[1], 1'b0};
      F3_SW:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO buffering UART transmit bytes; registered output, no write-through.
module tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  // Qualify requests against the registered occupancy
  always_comb begin
    full    = (cnt_q == CW'(DEPTH));
    empty   = (cnt_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem_q[rd_q];
  end

  // Storage, pointers and count; reset clears contents so the head reads zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/store_router.sv
// Store-side MMIO router: byte-lane enables/data for DMEM and IMEM, UART TX
// FIFO push with back-pressure stall, and a registered cycle-counter reset pulse.
// Optional STORE_ROUTER_MISALIGN_EN: misaligned SH/SW stores are suppressed and
// reported through sticky misalign / misalign_addr outputs.
module store_router
  import mmio_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] pc,
  output logic [3:0]  dmem_we,
  output logic [3:0]  imem_we,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic        cnt_rst,
  output logic        stall
`ifdef STORE_ROUTER_MISALIGN_EN
  ,
  output logic        misalign,
  output logic [31:0] misalign_addr
`endif
);

  logic [3:0] nib;
  logic [1:0] off;
  logic [3:0] mask;
  logic       is_dmem, is_imem, is_io;
  logic       bad_align, uart_hit, cnt_hit;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic       cnt_rst_q, cnt_rst_d;
  logic       unused_pc;

  assign unused_pc = ^{pc[31], pc[29:0]};

  // Region decode, lane alignment and IO register hits
  always_comb begin
    nib       = st_addr[31:28];
    off       = st_addr[1:0];
    mask      = lane_mask(st_funct3, off);
    bad_align = 1'b0;
`ifdef STORE_ROUTER_MISALIGN_EN
    bad_align = st_valid && (((st_funct3 == F3_SH) && off[0]) ||
                             ((st_funct3 == F3_SW) && (off != 2'b00)));
`endif
    is_dmem   = (nib[3:2] == REGION_DMEM_HI) && (nib[0] == REGION_DMEM_LO);
    is_imem   = (nib[3:1] == REGION_IMEM_HI) && pc[30];
    is_io     = (nib == REGION_IO);
    uart_hit  = st_valid && !bad_align && is_io && (st_addr == UART_TX_ADDR);
    cnt_hit   = st_valid && !bad_align && is_io && (st_addr == CNT_RST_ADDR);
    stall     = uart_hit && fifo_full;
    fifo_push = uart_hit && !fifo_full;
    fifo_pop  = uart_tx_valid && uart_tx_ready;
    cnt_rst_d = cnt_hit;
  end

  // Memory write port: enables gated by valid, region, alignment and stall
  always_comb begin
    dmem_we  = 4'b0000;
    imem_we  = 4'b0000;
    mem_addr = st_addr[15:2];
    case (st_funct3)
      F3_SB:   mem_din = {4{st_data[7:0]}};
      F3_SH:   mem_din = {2{st_data[15:0]}};
      default: mem_din = st_data;
    endcase
    if (st_valid && !bad_align && !stall) begin
      if (is_dmem) dmem_we = mask;
      if (is_imem) imem_we = mask;
    end
  end

  tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (st_data[7:0]),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (uart_tx_data),
    .empty (fifo_empty)
  );

  assign uart_tx_valid = !fifo_empty;

  // Counter-reset pulse lands the cycle after the store
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_rst_q <= 1'b0;
    else        cnt_rst_q <= cnt_rst_d;
  end

  assign cnt_rst = cnt_rst_q;

`ifdef STORE_ROUTER_MISALIGN_EN
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;

  // Sticky flag with first-offender address capture
  always_comb begin
    misalign_d      = misalign_q;
    misalign_addr_d = misalign_addr_q;
    if (bad_align && !misalign_q) begin
      misalign_d      = 1'b1;
      misalign_addr_d = st_addr;
    end
  end

  // Misalign state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;
`endif

endmodule

// File: tb/tb_store_router.sv
// Directed bench for store_router: memory lane checks inline, UART bytes via a
// scoreboard queue drained by an independent handshake monitor.
module tb_store_router;
  import mmio_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr, st_data, pc;
  logic [2:0]  st_funct3;
  logic [3:0]  dmem_we, imem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic        cnt_rst, stall;
`ifdef STORE_ROUTER_MISALIGN_EN
  logic        misalign;
  logic [31:0] misalign_addr;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  store_router #(.TX_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_funct3     (st_funct3),
    .pc            (pc),
    .dmem_we       (dmem_we),
    .imem_we       (imem_we),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .cnt_rst       (cnt_rst),
    .stall         (stall)
`ifdef STORE_ROUTER_MISALIGN_EN
    ,
    .misalign      (misalign),
    .misalign_addr (misalign_addr)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input logic [31:0] p);
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f;
    pc        = p;
    #1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  // UART monitor: pops expected bytes on each handshake, checks head stability under back-pressure
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold && uart_tx_valid) chk("tx_hold", 32'(uart_tx_data), 32'(prev_data));
      if (uart_tx_valid && uart_tx_ready) begin
        if (exp_q.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
        else chk("tx_byte", 32'(uart_tx_data), 32'(exp_q.pop_front()));
      end
    end
    prev_hold = rst_n && uart_tx_valid && !uart_tx_ready;
    prev_data = uart_tx_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    uart_tx_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, F3_SB, 32'h0);
    repeat (3) tick();
    #1;
    chk("rst_valid", 32'(uart_tx_valid), 32'd0);
    chk("rst_data",  32'(uart_tx_data),  32'd0);
    chk("rst_cnt",   32'(cnt_rst),       32'd0);
    chk("rst_stall", 32'(stall),         32'd0);
    chk("rst_dwe",   32'(dmem_we),       32'd0);
    chk("rst_iwe",   32'(imem_we),       32'd0);
    tick();
    rst_n = 1'b1;

    // DMEM byte store, top lane
    tick(); drive(1'b1, 32'h1000_0003, 32'h0000_00AB, F3_SB, 32'h0);
    chk("sb_dwe",  32'(dmem_we), 32'h8);
    chk("sb_din",  mem_din,      32'hABAB_ABAB);
    chk("sb_iwe",  32'(imem_we), 32'h0);
    chk("sb_addr", 32'(mem_addr), 32'h0);

    // IMEM word store gated by pc[30]
    tick(); drive(1'b1, 32'h2000_0004, 32'h1234_5678, F3_SW, 32'h4000_0000);
    chk("sw_iwe",  32'(imem_we), 32'hF);
    chk("sw_dwe",  32'(dmem_we), 32'h0);
    chk("sw_addr", 32'(mem_addr), 32'h1);
    chk("sw_din",  mem_din,      32'h1234_5678);
    tick(); drive(1'b1, 32'h2000_0004, 32'h1234_5678, F3_SW, 32'h0);
    chk("sw_iwe_pc0", 32'(imem_we), 32'h0);

    // Region 0x3 hits both DMEM and IMEM; halfword in upper lanes
    tick(); drive(1'b1, 32'h3000_0006, 32'h0000_BEEF, F3_SH, 32'h4000_0000);
    chk("sh_dwe",  32'(dmem_we), 32'hC);
    chk("sh_iwe",  32'(imem_we), 32'hC);
    chk("sh_din",  mem_din,      32'hBEEF_BEEF);
    chk("sh_addr", 32'(mem_addr), 32'h1);

    // Dropped region, bad funct3, no valid
    tick(); drive(1'b1, 32'h5000_0000, 32'hFFFF_FFFF, F3_SW, 32'h4000_0000);
    chk("drop_dwe", 32'(dmem_we), 32'h0);
    chk("drop_iwe", 32'(imem_we), 32'h0);
    tick(); drive(1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 3'b011, 32'h0);
    chk("f3_dwe", 32'(dmem_we), 32'h0);
    tick(); drive(1'b0, 32'h1000_0000, 32'hFFFF_FFFF, F3_SW, 32'h0);
    chk("novalid_dwe", 32'(dmem_we), 32'h0);

`ifndef STORE_ROUTER_MISALIGN_EN
    // Misaligned halfword truncates off[0]
    tick(); drive(1'b1, 32'h1000_000B, 32'h0000_CAFE, F3_SH, 32'h0);
    chk("shmis_dwe",  32'(dmem_we), 32'hC);
    chk("shmis_addr", 32'(mem_addr), 32'h2);
    chk("shmis_din",  mem_din,      32'hCAFE_CAFE);
`endif

    // Fill the UART FIFO with ready low
    for (int i = 0; i < 4; i++) begin
      tick(); drive(1'b1, UART_TX_ADDR, 32'(8'h41 + i), F3_SB, 32'h0);
      chk("fill_stall", 32'(stall),   32'd0);
      chk("fill_dwe",   32'(dmem_we), 32'd0);
      exp_q.push_back(8'(8'h41 + i));
    end
    tick(); drive(1'b1, UART_TX_ADDR, 32'h45, F3_SB, 32'h0);
    chk("full_valid", 32'(uart_tx_valid), 32'd1);
    chk("full_stall", 32'(stall),         32'd1);
    chk("full_dwe",   32'(dmem_we),       32'd0);
    tick(); uart_tx_ready = 1'b1; #1;
    chk("stall_with_pop", 32'(stall), 32'd1);
    tick();
    chk("retry_stall", 32'(stall), 32'd0);
    exp_q.push_back(8'h45);
    tick(); drive(1'b0, 32'h0, 32'h0, F3_SB, 32'h0);
    drain("drain_fill");
    tick(); tick();
    chk("empty_valid", 32'(uart_tx_valid), 32'd0);

    // No write-through: valid rises one cycle after push
    tick(); drive(1'b1, UART_TX_ADDR, 32'h55, F3_SB, 32'h0);
    chk("wt_valid0", 32'(uart_tx_valid), 32'd0);
    exp_q.push_back(8'h55);
    tick(); drive(1'b0, 32'h0, 32'h0, F3_SB, 32'h0);
    chk("wt_valid1", 32'(uart_tx_valid), 32'd1);
    drain("drain_wt");

    // Counter reset pulse, single and back-to-back
    tick(); drive(1'b1, CNT_RST_ADDR, 32'h0, F3_SW, 32'h0);
    chk("cnt_same", 32'(cnt_rst), 32'd0);
    tick(); drive(1'b0, 32'h0, 32'h0, F3_SB, 32'h0);
    chk("cnt_pulse", 32'(cnt_rst), 32'd1);
    tick();
    chk("cnt_end", 32'(cnt_rst), 32'd0);
    tick(); drive(1'b1, CNT_RST_ADDR, 32'h0, F3_SW, 32'h0);
    tick();
    chk("cnt_b2b_1", 32'(cnt_rst), 32'd1);
    tick(); drive(1'b0, 32'h0, 32'h0, F3_SB, 32'h0);
    chk("cnt_b2b_2", 32'(cnt_rst), 32'd1);
    tick();
    chk("cnt_b2b_end", 32'(cnt_rst), 32'd0);

    // Reset with bytes queued discards them
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b1, UART_TX_ADDR, 32'(8'h90 + i), F3_SB, 32'h0);
    end
    tick(); drive(1'b0, 32'h0, 32'h0, F3_SB, 32'h0);
    chk("pre_rst_valid", 32'(uart_tx_valid), 32'd1);
    tick(); rst_n = 1'b0; drive(1'b1, UART_TX_ADDR, 32'h99, F3_SB, 32'h0);
    tick();
    chk("midrst_valid", 32'(uart_tx_valid), 32'd0);
    chk("midrst_stall", 32'(stall),         32'd0);
    chk("midrst_data",  32'(uart_tx_data),  32'd0);
    tick(); rst_n = 1'b1; uart_tx_ready = 1'b1; drive(1'b0, 32'h0, 32'h0, F3_SB, 32'h0);
    repeat (3) tick();
    chk("postrst_valid", 32'(uart_tx_valid), 32'd0);

`ifdef STORE_ROUTER_MISALIGN_EN
    chk("mis_init", 32'(misalign), 32'd0);
    tick(); drive(1'b1, 32'h1000_0002, 32'hDEAD_BEEF, F3_SW, 32'h0);
    chk("mis_dwe", 32'(dmem_we), 32'd0);
    tick(); drive(1'b0, 32'h0, 32'h0, F3_SB, 32'h0);
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_addr", misalign_addr, 32'h1000_0002);
    tick(); drive(1'b1, 32'h1000_0001, 32'h0000_1234, F3_SH, 32'h0);
    chk("mis2_dwe", 32'(dmem_we), 32'd0);
    tick(); drive(1'b0, 32'h0, 32'h0, F3_SB, 32'h0);
    chk("mis2_flag", 32'(misalign), 32'd1);
    chk("mis2_addr", misalign_addr, 32'h1000_0002);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
